// File: rtl/multicycle_alu_if.sv
// rtl/multicycle_alu_if.sv - start/done handshake and operand/result bundle for multicycle_alu
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output start, operation, a, b,
    input  busy, done, result, zero, overflow, div_by_zero
  );

  modport slave (
    input  start, operation, a, b,
    output busy, done, result, zero, overflow, div_by_zero
  );
endinterface

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - ALU with single-cycle logic/arith ops and iterative MUL/DIVU/REMU
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            rst,
  multicycle_alu_if.slave bus
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_REMU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc;     // MUL partial product / DIVU,REMU partial remainder
  logic [WIDTH-1:0] mcand;   // MUL shifting multiplicand / DIVU,REMU divisor
  logic [WIDTH-1:0] shreg;   // MUL multiplier / DIVU,REMU dividend shifting into quotient
  logic [WIDTH-1:0] result_q;
  logic             zero_q, overflow_q, dbz_q;

  logic             is_multi;
  logic [WIDTH-1:0] sum, diff, single_res;
  logic             single_ovf;
  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem_next, quot_next, multi_res;

  assign is_multi = (bus.operation == OP_MUL) || (bus.operation == OP_DIVU) ||
                    (bus.operation == OP_REMU);
  assign sum  = bus.a + bus.b;
  assign diff = bus.a - bus.b;

  always_comb begin
    single_res = '0;
    single_ovf = 1'b0;
    case (bus.operation)
      OP_ADD: begin
        single_res = sum;
        single_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        single_res = diff;
        single_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_AND: single_res = bus.a & bus.b;
      OP_OR:  single_res = bus.a | bus.b;
      default: single_res = '0;
    endcase
  end

  // One restoring-division step: the remainder stays below the divisor, so WIDTH+1 bits suffice.
  assign mul_acc_next = shreg[0] ? acc + mcand : acc;
  assign div_shift    = {acc, shreg[WIDTH-1]};
  assign div_diff     = div_shift - {1'b0, mcand};
  assign div_ok       = !div_diff[WIDTH];
  assign div_rem_next = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quot_next    = {shreg[WIDTH-2:0], div_ok};
  assign multi_res    = (op_q == OP_MUL)  ? mul_acc_next :
                        (op_q == OP_DIVU) ? quot_next : div_rem_next;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = is_multi ? CALC : DONE;
      CALC: if (cnt == CNT_W'(1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      op_q       <= '0;
      acc        <= '0;
      mcand      <= '0;
      shreg      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !is_multi) begin
            result_q   <= single_res;
            zero_q     <= (single_res == '0);
            overflow_q <= single_ovf;
            dbz_q      <= 1'b0;
          end else if (bus.start) begin
            op_q  <= bus.operation;
            cnt   <= CNT_W'(WIDTH);
            acc   <= '0;
            mcand <= (bus.operation == OP_MUL) ? bus.a : bus.b;
            shreg <= (bus.operation == OP_MUL) ? bus.b : bus.a;
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (op_q == OP_MUL) begin
            acc   <= mul_acc_next;
            mcand <= mcand << 1;
            shreg <= shreg >> 1;
          end else begin
            acc   <= div_rem_next;
            shreg <= quot_next;
          end
          if (cnt == CNT_W'(1)) begin
            result_q   <= multi_res;
            zero_q     <= (multi_res == '0);
            overflow_q <= 1'b0;
            dbz_q      <= (op_q != OP_MUL) && (mcand == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.overflow    = overflow_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - randomized and directed self-checking bench for multicycle_alu
module tb_multicycle_alu;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(W)) bus ();

  multicycle_alu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_result(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    longint unsigned ua = a, ub = b;
    longint          sa = $signed(a), sb = $signed(b);
    case (op)
      3'b010: return W'(ua + ub);
      3'b110: return W'(ua - ub);
      3'b111: return (sa < sb) ? W'(1) : W'(0);
      3'b000: return a & b;
      3'b001: return a | b;
      3'b011: return W'(ua * ub);
      3'b100: return (b == 0) ? {W{1'b1}} : W'(ua / ub);
      default: return (b == 0) ? a : W'(ua % ub);
    endcase
  endfunction

  function automatic logic model_ovf(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    longint sa = $signed(a), sb = $signed(b), s;
    if (op == 3'b010)      s = sa + sb;
    else if (op == 3'b110) s = sa - sb;
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Launch one op and follow it to done; optional noise pulses start while busy.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit noise);
    logic [W-1:0] exp_res, prev;
    int           n, lat;
    bit           busy_ok, hold_ok;
    exp_res = model_result(op, a, b);
    lat     = (op == 3'b011 || op == 3'b100 || op == 3'b101) ? W + 1 : 1;
    @(negedge clk);
    prev          = bus.result;
    bus.start     = 1'b1;
    bus.operation = op;
    bus.a         = a;
    bus.b         = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!bus.done && n < 80) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.result !== prev) hold_ok = 1'b0;
      if (noise) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.operation = 3'($urandom);
        bus.a         = $urandom;
        bus.b         = $urandom;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " busy"}, 64'(busy_ok && bus.busy), 64'(1));
    check({tag, " hold"}, 64'(hold_ok), 64'(1));
    check({tag, " result"}, 64'(bus.result), 64'(exp_res));
    check({tag, " zero"}, 64'(bus.zero), 64'(exp_res == 0));
    check({tag, " overflow"}, 64'(bus.overflow), 64'(model_ovf(op, a, b)));
    check({tag, " div_by_zero"}, 64'(bus.div_by_zero),
          64'((op == 3'b100 || op == 3'b101) && b == 0));
    @(negedge clk);
    check({tag, " idle after"}, 64'({bus.busy, bus.done}), 64'(0));
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] ra, rb;
    bit           done_seen;

    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.operation = 3'b010;
    bus.a         = 32'd3;
    bus.b         = 32'd4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset busy", 64'(bus.busy), 64'(0));
      check("reset done", 64'(bus.done), 64'(0));
      check("reset result", 64'(bus.result), 64'(0));
      check("reset flags", 64'({bus.zero, bus.overflow, bus.div_by_zero}), 64'(0));
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("no launch after reset", 64'(bus.busy), 64'(0));

    run_op("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h1, 1'b0);
    run_op("slt_neg", 3'b111, 32'h8000_0000, 32'h1, 1'b0);
    run_op("sub_zero", 3'b110, 32'd5, 32'd5, 1'b0);
    run_op("and", 3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
    run_op("or", 3'b001, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
    run_op("mul_noise", 3'b011, 32'h0001_0003, 32'h0002_0005, 1'b1);
    run_op("divu", 3'b100, 32'd100, 32'd7, 1'b0);
    run_op("remu", 3'b101, 32'd100, 32'd7, 1'b0);
    run_op("divu_b0", 3'b100, 32'd1234, 32'd0, 1'b0);
    run_op("remu_b0", 3'b101, 32'd1234, 32'd0, 1'b0);
    run_op("sub_ovf", 3'b110, 32'h8000_0000, 32'h1, 1'b0);

    // Reset during the 10th CALC cycle of a MUL.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.operation = 3'b011;
    bus.a         = 32'h1234;
    bus.b         = 32'h5678;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(bus.busy), 64'(0));
    check("abort result", 64'(bus.result), 64'(0));
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) done_seen = 1'b1;
      @(negedge clk);
    end
    check("abort no done", 64'(done_seen), 64'(0));

    for (int t = 0; t < 150; t++) begin
      op = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = W'($urandom_range(0, 300)); rb = W'($urandom_range(1, 20)); end
        2: ra = rb;
        default: ;
      endcase
      run_op("rand", op, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
